mem_port_arbiter: RTL

Sequences and shares the single unified memory port between the instruction-fetch stage and the load/store (data memory) stage of the RISC-V core. Accepts one transaction at a time from either requester, drives a variable-latency request/ready memory interface, and returns read data and completion to the owning requester. Sits between the fetch/memory pipeline stages and the memory wrapper; the pipeline stalls on missing grant or response.

---
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one request/ready memory port between instruction fetch and load/store.
// Optional ARB_RR_EN selects round-robin on contention instead of fixed DM > IF priority.
module mem_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [XLEN-1:0]       if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [XLEN/8-1:0]     dm_be,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [XLEN-1:0]       dm_wdata,
  output logic                  dm_gnt,
  output logic                  dm_rvalid,
  output logic [XLEN-1:0]       dm_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [XLEN/8-1:0]     mem_be,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [XLEN-1:0]       mem_wdata,
  input  logic                  mem_ready,
  input  logic [XLEN-1:0]       mem_rdata,
  output logic [1:0]            dbg_state
);

  // Handshakes: a requester holds req and fields until its gnt pulse (same
  // cycle, combinational); rvalid pulses once when its transaction completes.
  // mem_req is held with stable fields until the memory answers with mem_ready.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  state_t                state_q, state_d;
  owner_t                owner_q;
  logic                  we_q;
  logic [XLEN/8-1:0]     be_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [XLEN-1:0]       wdata_q;
  logic [XLEN-1:0]       if_rdata_q, dm_rdata_q;
  logic                  grant_if, grant_dm;
  logic                  pick_dm;
  logic                  arb_ok;

`ifdef ARB_RR_EN
  owner_t last_gnt_q;

  // On contention the requester that was not granted last time wins.
  always_comb begin
    pick_dm = dm_req && (!if_req || (last_gnt_q == OWN_IF));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt_q <= OWN_IF;
    end else if (grant_dm) begin
      last_gnt_q <= OWN_DM;
    end else if (grant_if) begin
      last_gnt_q <= OWN_IF;
    end
  end
`else
  always_comb begin
    pick_dm = dm_req;
  end
`endif

  // Gating with rst keeps grants quiet while reset is held.
  assign arb_ok = (state_q != S_BUSY) && !rst;

  always_comb begin
    state_d  = state_q;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (arb_ok && (if_req || dm_req)) begin
          grant_dm = pick_dm;
          grant_if = !pick_dm;
          state_d  = S_BUSY;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_BUSY: begin
        if (mem_ready) begin
          state_d = S_RESP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= OWN_IF;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant_dm) begin
      owner_q <= OWN_DM;
      we_q    <= dm_we;
      be_q    <= dm_be;
      addr_q  <= dm_addr;
      wdata_q <= dm_wdata;
    end else if (grant_if) begin
      owner_q <= OWN_IF;
      we_q    <= 1'b0;
      be_q    <= '1;
      addr_q  <= if_addr;
      wdata_q <= '0;
    end
  end

  // Stores complete without touching the read-data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else if ((state_q == S_BUSY) && mem_ready && !we_q) begin
      if (owner_q == OWN_DM) begin
        dm_rdata_q <= mem_rdata;
      end else begin
        if_rdata_q <= mem_rdata;
      end
    end
  end

  assign if_gnt    = grant_if;
  assign dm_gnt    = grant_dm;
  assign if_rvalid = (state_q == S_RESP) && (owner_q == OWN_IF);
  assign dm_rvalid = (state_q == S_RESP) && (owner_q == OWN_DM);
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_req   = (state_q == S_BUSY);
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign dbg_state = state_q;

endmodule
